// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable serial pattern detector.
package seq_det_pkg;
  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_e;

  localparam logic [3:0] DEF_PATTERN = 4'b1001;
  localparam int         DEF_LEN     = 4;
  localparam logic       DEF_OVERLAP = 1'b1;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-input / status bundle between the line front end and the detector.
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = seq_det_pkg::len_w(PAT_W)
);
  logic             x;
  logic             x_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output x, x_valid, cfg_load, pattern, pat_len, overlap, cnt_clr,
                  input  match, match_cnt, cnt_sat);
  modport slave  (input  x, x_valid, cfg_load, pattern, pat_len, overlap, cnt_clr,
                  output match, match_cnt, cnt_sat);
endinterface

// File: rtl/seq_det_match_counter.sv
// Saturating event counter; a clear coincident with an event restarts at one.
module seq_det_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            cnt <= '0;
    else if (clr)        cnt <= inc ? CNT_W'(1) : '0;
    else if (inc && !sat) cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control,
// registered match pulse and saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = len_w(PAT_W)
) (
  input logic                clk,
  input logic                rst,
  seq_detector_param_if.slave bus
);
  logic [PAT_W-1:0] pat_q, hist_q, hist_n;
  logic [LEN_W-1:0] len_q, fill_q, fill_n, fill_inc, len_clamp;
  logic             ovl_q, match_q, hit, eq, armed_n;
  state_e           state_q, state_n;

  always_comb begin
    len_clamp = bus.pat_len;
    if (bus.pat_len == '0)                  len_clamp = LEN_W'(1);
    else if (bus.pat_len > LEN_W'(PAT_W))   len_clamp = LEN_W'(PAT_W);
  end

  // Compare only the low len bits of the post-shift history.
  always_comb begin
    hist_n   = {hist_q[PAT_W-2:0], bus.x};
    fill_inc = (fill_q >= LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    eq       = 1'b1;
    for (int i = 0; i < PAT_W; i++)
      if (i < int'(len_q) && hist_n[i] != pat_q[i]) eq = 1'b0;
    armed_n  = (state_q == ARMED) || (fill_inc >= len_q);
    hit      = bus.x_valid && !bus.cfg_load && armed_n && eq;
  end

  always_comb begin
    fill_n  = fill_q;
    state_n = state_q;
    if (bus.cfg_load) begin
      fill_n  = '0;
      state_n = FILL;
    end else if (bus.x_valid) begin
      if (hit && !ovl_q) begin
        fill_n  = '0;
        state_n = FILL;
      end else begin
        fill_n = fill_inc;
        if (armed_n) state_n = ARMED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q   <= PAT_W'(DEF_PATTERN);
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      fill_q  <= fill_n;
      state_q <= state_n;
      if (bus.cfg_load) begin
        pat_q  <= bus.pattern;
        len_q  <= len_clamp;
        ovl_q  <= bus.overlap;
        hist_q <= '0;
      end else if (bus.x_valid) begin
        hist_q <= hist_n;
      end
    end
  end

  // The counter counts the registered pulse, so it settles one cycle after match.
  seq_det_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_q),
    .clr (bus.cnt_clr),
    .cnt (bus.match_cnt),
    .sat (bus.cnt_sat)
  );

  assign bus.match = match_q;
endmodule
